// File: rtl/regfile_wb_arbiter_if.sv
// Writeback-side bundle between execute/memory stages, decode and the register-file write ports.
// slave: the arbiter; master: the stage/decode side driving requests.
interface regfile_wb_arbiter_if #(
  parameter int unsigned AW = 5,
  parameter int unsigned DW = 32
) ();
  logic          alu_valid;
  logic          alu_ready;
  logic [AW-1:0] alu_waddr;
  logic [DW-1:0] alu_wdata;
  logic          alu_is_upper;

  logic          mem_valid;
  logic          mem_ready;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;

  logic          link_valid;
  logic [DW-1:0] link_data;

  logic          issue_valid;
  logic [AW-1:0] issue_waddr;
  logic          issue_ready;

  logic [AW-1:0] raddr0;
  logic [AW-1:0] raddr1;
  logic          rs0_busy;
  logic          rs1_busy;
  logic          rs0_fwd_valid;
  logic          rs1_fwd_valid;
  logic [DW-1:0] rs0_fwd_data;
  logic [DW-1:0] rs1_fwd_data;

  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic          rf_wren;
  logic          rf_is_upper;
  logic          rf_jal_wren;
  logic [DW-1:0] rf_jal_data;

  modport slave (
    input  alu_valid, alu_waddr, alu_wdata, alu_is_upper,
    input  mem_valid, mem_waddr, mem_wdata,
    input  link_valid, link_data,
    input  issue_valid, issue_waddr,
    input  raddr0, raddr1,
    output alu_ready, mem_ready, issue_ready,
    output rs0_busy, rs1_busy, rs0_fwd_valid, rs1_fwd_valid, rs0_fwd_data, rs1_fwd_data,
    output rf_waddr, rf_wdata, rf_wren, rf_is_upper, rf_jal_wren, rf_jal_data
  );

  modport master (
    output alu_valid, alu_waddr, alu_wdata, alu_is_upper,
    output mem_valid, mem_waddr, mem_wdata,
    output link_valid, link_data,
    output issue_valid, issue_waddr,
    output raddr0, raddr1,
    input  alu_ready, mem_ready, issue_ready,
    input  rs0_busy, rs1_busy, rs0_fwd_valid, rs1_fwd_valid, rs0_fwd_data, rs1_fwd_data,
    input  rf_waddr, rf_wdata, rf_wren, rf_is_upper, rf_jal_wren, rf_jal_data
  );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Round-robin ALU/load writeback arbiter with JAL link port and load scoreboard for decode stalls.
// Optional macro RF_ARB_BYPASS_EN: forward in-flight writes instead of stalling on them.
module regfile_wb_arbiter #(
  parameter int unsigned AW       = 5,
  parameter int unsigned DW       = 32,
  parameter int unsigned LINK_REG = 31
) (
  input logic                clk,
  input logic                rst,
  regfile_wb_arbiter_if.slave bus
);

  localparam int unsigned   NumRegs  = 1 << AW;
  localparam logic [AW-1:0] LinkAddr = AW'(LINK_REG);

  typedef enum logic {StAluFirst, StMemFirst} prio_e;

  prio_e              prio_q, prio_d;
  logic [NumRegs-1:0] busy_q, busy_d;
  logic               rf_wren_q, rf_wren_d;
  logic [AW-1:0]      rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]      rf_wdata_q, rf_wdata_d;
  logic               rf_is_upper_q, rf_is_upper_d;
  logic               rf_jal_wren_q, rf_jal_wren_d;
  logic [DW-1:0]      rf_jal_data_q, rf_jal_data_d;

  logic          cand_alu, cand_mem, link_block;
  logic [AW-1:0] cand_addr;
  logic          alu_gnt, mem_gnt, issue_ready, issue_go;

  always_comb begin
    cand_alu = 1'b0;
    cand_mem = 1'b0;
    if (bus.alu_valid && bus.mem_valid) begin
      cand_alu = (prio_q == StAluFirst);
      cand_mem = (prio_q == StMemFirst);
    end else begin
      cand_alu = bus.alu_valid;
      cand_mem = bus.mem_valid;
    end
    cand_addr  = cand_alu ? bus.alu_waddr : bus.mem_waddr;
    // The link write owns LINK_REG this cycle; hold off whichever requester targets it.
    link_block = bus.link_valid && (cand_alu || cand_mem) && (cand_addr == LinkAddr);
    alu_gnt    = cand_alu && !link_block && !rst;
    mem_gnt    = cand_mem && !link_block && !rst;
    issue_ready = !rst && !busy_q[bus.issue_waddr];
    issue_go    = bus.issue_valid && issue_ready;
  end

  assign bus.alu_ready   = alu_gnt;
  assign bus.mem_ready   = mem_gnt;
  assign bus.issue_ready = issue_ready;

  always_comb begin
    prio_d = prio_q;
    if (alu_gnt) begin
      prio_d = StMemFirst;
    end else if (mem_gnt) begin
      prio_d = StAluFirst;
    end

    rf_wren_d     = 1'b0;
    rf_waddr_d    = '0;
    rf_wdata_d    = '0;
    rf_is_upper_d = 1'b0;
    // r0 writes finish their handshake but never reach the regfile.
    if (alu_gnt && (bus.alu_waddr != '0)) begin
      rf_wren_d     = 1'b1;
      rf_waddr_d    = bus.alu_waddr;
      rf_wdata_d    = bus.alu_wdata;
      rf_is_upper_d = bus.alu_is_upper;
    end else if (mem_gnt && (bus.mem_waddr != '0)) begin
      rf_wren_d     = 1'b1;
      rf_waddr_d    = bus.mem_waddr;
      rf_wdata_d    = bus.mem_wdata;
    end

    rf_jal_wren_d = bus.link_valid;
    rf_jal_data_d = bus.link_valid ? bus.link_data : '0;

    busy_d = busy_q;
    if (mem_gnt) begin
      busy_d[bus.mem_waddr] = 1'b0;
    end
    // Applied after the clear so a same-register set wins.
    if (issue_go && (bus.issue_waddr != '0)) begin
      busy_d[bus.issue_waddr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      prio_q        <= StAluFirst;
      busy_q        <= '0;
      rf_wren_q     <= 1'b0;
      rf_waddr_q    <= '0;
      rf_wdata_q    <= '0;
      rf_is_upper_q <= 1'b0;
      rf_jal_wren_q <= 1'b0;
      rf_jal_data_q <= '0;
    end else begin
      prio_q        <= prio_d;
      busy_q        <= busy_d;
      rf_wren_q     <= rf_wren_d;
      rf_waddr_q    <= rf_waddr_d;
      rf_wdata_q    <= rf_wdata_d;
      rf_is_upper_q <= rf_is_upper_d;
      rf_jal_wren_q <= rf_jal_wren_d;
      rf_jal_data_q <= rf_jal_data_d;
    end
  end

  assign bus.rf_wren     = rf_wren_q;
  assign bus.rf_waddr    = rf_waddr_q;
  assign bus.rf_wdata    = rf_wdata_q;
  assign bus.rf_is_upper = rf_is_upper_q;
  assign bus.rf_jal_wren = rf_jal_wren_q;
  assign bus.rf_jal_data = rf_jal_data_q;

  logic [AW-1:0] raddr        [2];
  logic          wr_hit       [2];
  logic          jal_hit      [2];
  logic          rs_busy      [2];
  logic          rs_fwd_valid [2];
  logic [DW-1:0] rs_fwd_data  [2];

  assign raddr[0] = bus.raddr0;
  assign raddr[1] = bus.raddr1;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wr_hit[p]       = rf_wren_q && (rf_waddr_q == raddr[p]) && (raddr[p] != '0);
      jal_hit[p]      = rf_jal_wren_q && (raddr[p] == LinkAddr) && (raddr[p] != '0);
      rs_busy[p]      = 1'b0;
      rs_fwd_valid[p] = 1'b0;
      rs_fwd_data[p]  = '0;
`ifdef RF_ARB_BYPASS_EN
      rs_busy[p]      = (raddr[p] != '0) && busy_q[raddr[p]];
      rs_fwd_valid[p] = wr_hit[p] || jal_hit[p];
      if (jal_hit[p]) begin
        rs_fwd_data[p] = rf_jal_data_q;
      end else if (wr_hit[p]) begin
        rs_fwd_data[p] = rf_is_upper_q ? (rf_wdata_q << 16) : rf_wdata_q;
      end
`else
      // Without forwarding, a write still in its regfile cycle is not yet readable.
      rs_busy[p] = (raddr[p] != '0) && (busy_q[raddr[p]] || wr_hit[p] || jal_hit[p]);
`endif
    end
  end

  assign bus.rs0_busy      = rs_busy[0];
  assign bus.rs1_busy      = rs_busy[1];
  assign bus.rs0_fwd_valid = rs_fwd_valid[0];
  assign bus.rs1_fwd_valid = rs_fwd_valid[1];
  assign bus.rs0_fwd_data  = rs_fwd_data[0];
  assign bus.rs1_fwd_data  = rs_fwd_data[1];

endmodule
